// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;
  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } loader_state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus seen by the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // master: host link plus memory side; slave: the loader itself
  modport master (output byte_data, byte_valid,
                  input  byte_ready, imem_we, imem_addr, imem_wdata);
  modport slave  (input  byte_data, byte_valid,
                  output byte_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream; word_valid pulses
// the cycle after the fourth byte of a word is accepted.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic [1:0]  byte_cnt,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [23:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= 2'd0;
      acc        <= 24'd0;
      word_valid <= 1'b0;
      word       <= 32'd0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_cnt <= 2'd0;
      end else if (in_valid) begin
        if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
          // top lane arrives straight into the output word, leaving acc free
          word       <= {in_byte, acc};
          word_valid <= 1'b1;
          byte_cnt   <= 2'd0;
        end else begin
          case (byte_cnt)
            2'd0:    acc[7:0]   <= in_byte;
            2'd1:    acc[15:8]  <= in_byte;
            default: acc[23:16] <= in_byte;
          endcase
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header, N little-endian words into instruction memory,
// then core release. Optional trailing checksum byte under IMEM_LOADER_CSUM_EN.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus,
  output logic         core_rst_n,
  output logic         load_done,
  output logic         load_err
);
  localparam int DEPTH = 2**ADDR_W;
`ifdef IMEM_LOADER_CSUM_EN
  localparam loader_state_e S_END = S_CSUM;
`else
  localparam loader_state_e S_END = S_DONE;
`endif

  loader_state_e     state, state_nxt;
  logic              ready_en, accepting, xfer, data_xfer, word_done;
  logic              word_valid;
  logic [1:0]        byte_cnt;
  logic [7:0]        len_lo;
  logic [LEN_W-1:0]  n_full, n_words, word_cnt;
  logic [31:0]       word;
  logic [ADDR_W-1:0] addr_q;

  assign accepting = (state == S_LEN0) || (state == S_LEN1) ||
                     (state == S_DATA) || (state == S_CSUM);
  assign bus.byte_ready = ready_en && accepting;
  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign data_xfer = xfer && (state == S_DATA);
  assign word_done = data_xfer && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign n_full    = LEN_W'({bus.byte_data, len_lo});

  assign bus.imem_we    = word_valid;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst),
    .clear      (state != S_DATA),
    .in_valid   (data_xfer),
    .in_byte    (bus.byte_data),
    .byte_cnt   (byte_cnt),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           csum <= 8'd0;
    else if (data_xfer) csum <= csum + bus.byte_data;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LEN0;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN0: if (xfer) state_nxt = S_LEN1;
      S_LEN1: begin
        if (xfer) begin
          if (n_full == '0)                 state_nxt = S_END;
          else if (32'(n_full) > 32'(DEPTH)) state_nxt = S_ERR;
          else                              state_nxt = S_DATA;
        end
      end
      S_DATA: if (word_done && ((word_cnt + LEN_W'(1)) == n_words)) state_nxt = S_END;
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM: if (xfer) state_nxt = (bus.byte_data == csum) ? S_DONE : S_ERR;
`endif
      default: ;
    endcase
  end

  // the write pulse for the final word lands in the first S_DONE cycle, so
  // registering the release from state guarantees it follows that write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en   <= 1'b0;
      len_lo     <= 8'd0;
      n_words    <= '0;
      word_cnt   <= '0;
      addr_q     <= '0;
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (xfer && (state == S_LEN0)) len_lo  <= bus.byte_data;
      if (xfer && (state == S_LEN1)) n_words <= n_full;
      if (word_done) begin
        addr_q   <= word_cnt[ADDR_W-1:0];
        word_cnt <= word_cnt + LEN_W'(1);
      end
      core_rst_n <= (state == S_DONE);
      load_done  <= (state == S_DONE);
      load_err   <= (state == S_ERR);
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; checksum cases run when IMEM_LOADER_CSUM_EN is defined.
module tb_imem_loader;
  import loader_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_rst_n, load_done, load_err;

  int total = 0;
  int bad   = 0;

  int          wr_addr[$];
  int          wr_bytes[$];
  logic [31:0] wr_data[$];
  int          xfers = 0;

  imem_loader_if #(.ADDR_W(10)) bus();

  imem_loader #(.ADDR_W(10), .LEN_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  // records each write with the number of bytes accepted before it
  always @(negedge clk) begin
    if (!rst) begin
      xfers = 0;
      wr_addr.delete();
      wr_data.delete();
      wr_bytes.delete();
    end else begin
      if (bus.imem_we) begin
        wr_addr.push_back(int'(bus.imem_addr));
        wr_data.push_back(bus.imem_wdata);
        wr_bytes.push_back(xfers);
      end
      if (bus.byte_valid && bus.byte_ready) xfers++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wd(input int i);
    return (i < wr_data.size()) ? wr_data[i] : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] wa(input int i);
    return (i < wr_addr.size()) ? 32'(wr_addr[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] wb(input int i);
    return (i < wr_bytes.size()) ? 32'(wr_bytes[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic apply_reset();
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // returns 1 ns after the edge on which the byte transferred
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget = 0;
    if (gaps) begin
      for (int k = 0; k < 8 && $urandom_range(1, 0) == 1; k++) begin
        @(posedge clk);
        #1;
      end
    end
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    while (!bus.byte_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.byte_ready) check("ready_timeout", 32'(bus.byte_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  logic [7:0] img_two [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
                               8'h93, 8'h05, 8'h10, 8'h00};
  logic [7:0] img_one [6]  = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    #2 rst = 1'b0;
    #20;
    check("rst_ready",  32'(bus.byte_ready), 32'd0);
    check("rst_we",     32'(bus.imem_we),    32'd0);
    check("rst_addr",   32'(bus.imem_addr),  32'd0);
    check("rst_wdata",  bus.imem_wdata,      32'd0);
    check("rst_core",   32'(core_rst_n),     32'd0);
    check("rst_done",   32'(load_done),      32'd0);
    check("rst_err",    32'(load_err),       32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready",  32'(bus.byte_ready), 32'd1);

`ifndef IMEM_LOADER_CSUM_EN
    // two words back-to-back
    foreach (img_two[i]) send_byte(img_two[i], 1'b0);
    check("b2b_we_last",   32'(bus.imem_we),   32'd1);
    check("b2b_addr_last", 32'(bus.imem_addr), 32'd1);
    check("b2b_core_pre",  32'(core_rst_n),    32'd0);
    @(posedge clk);
    #1;
    check("b2b_core_rel",  32'(core_rst_n),    32'd1);
    check("b2b_done",      32'(load_done),     32'd1);
    check("b2b_we_idle",   32'(bus.imem_we),   32'd0);
    check("b2b_addr_hold", 32'(bus.imem_addr), 32'd1);
    check("b2b_nwr",       32'(wr_data.size()), 32'd2);
    check("b2b_a0", wa(0), 32'd0);
    check("b2b_d0", wd(0), 32'h0000_0513);
    check("b2b_a1", wa(1), 32'd1);
    check("b2b_d1", wd(1), 32'h0010_0593);

    // same image with random idle cycles
    apply_reset();
    foreach (img_two[i]) send_byte(img_two[i], 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("gap_done", 32'(load_done), 32'd1);
    check("gap_nwr",  32'(wr_data.size()), 32'd2);
    check("gap_d0",   wd(0), 32'h0000_0513);
    check("gap_d1",   wd(1), 32'h0010_0593);
    check("gap_b0",   wb(0), 32'd6);
    check("gap_b1",   wb(1), 32'd10);
    check("gap_a1",   wa(1), 32'd1);

    // oversize header
    apply_reset();
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("big_err",   32'(load_err),       32'd1);
    check("big_done",  32'(load_done),      32'd0);
    check("big_ready", 32'(bus.byte_ready), 32'd0);
    check("big_core",  32'(core_rst_n),     32'd0);
    bus.byte_data  = 8'h55;
    bus.byte_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    check("big_nwr",   32'(wr_data.size()), 32'd0);
    check("big_err2",  32'(load_err),       32'd1);

    // empty image
    apply_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("zero_done_early", 32'(load_done), 32'd0);
    @(posedge clk);
    #1;
    check("zero_done", 32'(load_done),      32'd1);
    check("zero_core", 32'(core_rst_n),     32'd1);
    check("zero_nwr",  32'(wr_data.size()), 32'd0);

    // reset in the middle of a load, then a fresh one-word image
    apply_reset();
    for (int i = 0; i < 8; i++) send_byte(img_two[i], 1'b0);
    check("mid_nwr_pre", 32'(wr_data.size()), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_core",  32'(core_rst_n),     32'd0);
    check("mid_ready", 32'(bus.byte_ready), 32'd0);
    apply_reset();
    foreach (img_one[i]) send_byte(img_one[i], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_nwr",  32'(wr_data.size()), 32'd1);
    check("mid_a0",   wa(0), 32'd0);
    check("mid_d0",   wd(0), 32'hDEAD_BEEF);
    check("mid_done", 32'(load_done), 32'd1);

    // full-depth image (N == DEPTH)
    apply_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    for (int i = 0; i < 1024; i++) begin
      logic [15:0] iv;
      iv = 16'(i);
      send_byte(iv[7:0],  1'b0);
      send_byte(iv[15:8], 1'b0);
      send_byte(8'hA5,    1'b0);
      send_byte(8'h5A,    1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    begin
      int errs = 0;
      for (int i = 0; i < wr_data.size(); i++) begin
        if (wr_addr[i] != i || wr_data[i] != (32'h5AA5_0000 | 32'(i))) errs++;
      end
      check("depth_nwr",   32'(wr_data.size()), 32'd1024);
      check("depth_words", 32'(errs),           32'd0);
      check("depth_last",  wa(1023),            32'd1023);
      check("depth_done",  32'(load_done),      32'd1);
      check("depth_err",   32'(load_err),       32'd0);
    end
`else
    // good checksum
    foreach (img_one[i]) send_byte(img_one[i], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("cs_wait_done",  32'(load_done),      32'd0);
    check("cs_wait_ready", 32'(bus.byte_ready), 32'd1);
    check("cs_d0",         wd(0),               32'hDEAD_BEEF);
    send_byte(8'h38, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("cs_ok_done", 32'(load_done),  32'd1);
    check("cs_ok_err",  32'(load_err),   32'd0);
    check("cs_ok_core", 32'(core_rst_n), 32'd1);

    // bad checksum
    apply_reset();
    foreach (img_one[i]) send_byte(img_one[i], 1'b0);
    send_byte(8'h39, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("cs_bad_err",   32'(load_err),       32'd1);
    check("cs_bad_done",  32'(load_done),      32'd0);
    check("cs_bad_core",  32'(core_rst_n),     32'd0);
    check("cs_bad_nwr",   32'(wr_data.size()), 32'd1);

    // empty image still needs its checksum byte
    apply_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("cs_zero_wait", 32'(load_done), 32'd0);
    send_byte(8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("cs_zero_done", 32'(load_done), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the single-cycle core.
- Receives a byte stream from a host link (UART receiver or testbench) over a valid/ready handshake.
- Assembles little-endian 32-bit words and writes them into the instruction memory write port.
- Holds the core in reset until the whole image has been written, then releases it.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; depth DEPTH = 2**ADDR_W words.
- LEN_W, 16, width of the word-count header field.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- byte_data  input  8  incoming byte
- byte_valid  input  1  byte_data is valid
- byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready
- imem_we  output  1  instruction-memory write strobe, one-cycle pulse per word
- imem_addr  output  ADDR_W  word address of the write
- imem_wdata  output  32  word to write
- core_rst_n  output  1  active-low reset to the core; low while loading
- load_done  output  1  image loaded successfully (sticky)
- load_err  output  1  protocol error (sticky)

Behaviour:
- Reset (rst low, asynchronous):
  - state=S_LEN0; byte counter, word counter and checksum are 0.
  - imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, load_done=0, load_err=0.
  - byte_ready=0 while rst is low, 1 from the first clock after release.
- Stream format: 2-byte little-endian word count N (LEN_W bits), then N words of 4 bytes each, least-significant byte first.
- FSM states: S_LEN0, S_LEN1, S_DATA, S_CSUM (feature only), S_DONE, S_ERR.
  - byte_ready=1 in S_LEN0, S_LEN1, S_DATA and S_CSUM; 0 in S_DONE and S_ERR.
  - S_LEN0 --xfer--> S_LEN1, latching N[7:0].
  - S_LEN1 --xfer--> next state chosen from the completed N:
    - N=0 goes to S_DONE (without the feature) or S_CSUM (with the feature).
    - N>DEPTH goes to S_ERR.
    - Otherwise goes to S_DATA.
  - S_DATA: each transfer shifts the byte into lane byte_cnt (0..3).
    - On the transfer with byte_cnt==3, the full word is registered.
    - Next cycle: imem_we=1, imem_addr=word_cnt, imem_wdata=assembled word; word_cnt then increments.
    - When the word that completes count N is accepted, go to S_DONE (or S_CSUM with the feature).
    - Write latency is 1 cycle after the 4th byte's transfer.
    - imem_we is never high for two consecutive words without 4 intervening transfers.
    - imem_addr holds its last value when imem_we=0.
  - S_DONE: load_done=1; core_rst_n goes high one cycle after S_DONE is entered, so the final imem_we pulse always precedes core release. The FSM stays in S_DONE until rst.
  - S_ERR: load_err=1; core_rst_n stays 0; bytes are not accepted. The FSM stays in S_ERR until rst.
- byte_valid low in any state: no state change; the partial word is retained indefinitely (no timeout).
- N==DEPTH is legal: the last write goes to address DEPTH-1 and word_cnt does not wrap before S_DONE.
- Reset mid-load: the FSM returns to S_LEN0 and core_rst_n drops low immediately. Memory contents already written are left as-is; the new image overwrites them.
- load_done and load_err are never both 1.

Optional Feature:
- Macro: IMEM_LOADER_CSUM_EN.
- Defined:
  - The checksum is a running 8-bit sum (mod 256) of all data bytes. Header bytes are excluded.
  - After the last data byte (or directly after the header when N=0) the FSM enters S_CSUM and accepts one checksum byte.
  - If that byte equals the running sum, go to S_DONE; otherwise go to S_ERR.
  - Words already written are not rolled back.
- Not defined: S_CSUM, the checksum register and its logic are absent; the last data word leads directly to S_DONE.

Decomposition:
- Shared package loader_pkg holds:
  - state enum loader_state_e;
  - constants HDR_BYTES=2 and BYTES_PER_WORD=4.
- One natural sub-module: byte_packer.
  - Shifts in bytes, tracks the 0..3 lane count, and emits word_valid plus a 32-bit word.
  - Has a clear input for reset and state changes.
- The FSM, counters, checksum and output registers stay in imem_loader.

Test Plan:
- Header 0x02,0x00, then bytes 13 05 00 00 93 05 10 00 back-to-back:
  - imem_we pulses at addr 0 with 0x00000513, then at addr 1 with 0x00100593.
  - load_done=1; core_rst_n rises one cycle after the S_DONE entry.
- Same stream with byte_valid toggled randomly 50%: identical writes and values; no write while fewer than 4 bytes of a word have been accepted.
- Header 0x01,0x04 (N=1025 > DEPTH=1024): no imem_we; load_err=1; byte_ready=0; core_rst_n stays 0.
- Header 0x00,0x00: no writes; load_done=1 two cycles after the second byte (feature off).
- rst asserted after 6 data bytes, then a full 1-word image (01 00 EF BE AD DE): single write at addr 0 of 0xDEADBEEF; load_done=1.
- IMEM_LOADER_CSUM_EN defined, 1 word EF BE AD DE:
  - checksum byte 0x38 (0xEF+0xBE+0xAD+0xDE mod 256) leads to load_done=1;
  - checksum byte 0x39 leads to load_err=1 and core_rst_n=0.
